// File: rtl/am_mod_gen.sv
// AM generator: carrier and message NCOs sharing a sine LUT, envelope x carrier in a 4-stage pipeline.
// Optional `AM_DSB_SC_EN adds suppressed-carrier mode. The quarter-wave table is built for LUT_AW=8, SAMPLE_W=8.
module am_mod_gen #(
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = 8,
    parameter int SAMPLE_W = 8,
    parameter int OUT_W    = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       cfg_load,
    input  logic [PHASE_W-1:0]         carrier_fcw,
    input  logic [PHASE_W-1:0]         msg_fcw,
    input  logic [7:0]                 depth,
    input  logic                       sc_mode,
    output logic                       cfg_ack,
    output logic signed [OUT_W-1:0]    am_out,
    output logic                       am_valid
);

    localparam int ENV_W  = SAMPLE_W + 9;
    localparam int PROD_W = 2 * SAMPLE_W + 9;
    localparam int SH     = 2 * SAMPLE_W + 8 - OUT_W;

    localparam logic signed [ENV_W-1:0] ENV_OFS  = ENV_W'(2 ** (SAMPLE_W + 7));
    localparam logic signed [PROD_W:0]  RND_HALF = (PROD_W + 1)'(2 ** (SH - 1));
    localparam logic signed [PROD_W:0]  OMAX     = (PROD_W + 1)'(2 ** (OUT_W - 1) - 1);

    // round(127*sin(2*pi*k/256)), k = 0..64
    localparam logic [7:0] QTAB [0:64] = '{
        8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,
        8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
        8'd49,  8'd51,  8'd54,  8'd57,  8'd60,  8'd63,  8'd65,  8'd68,
        8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,  8'd85,  8'd88,
        8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
        8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116,
        8'd117, 8'd118, 8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124,
        8'd125, 8'd125, 8'd126, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127,
        8'd127
    };

    function automatic logic signed [SAMPLE_W-1:0] lut_rd(input logic [LUT_AW-1:0] a);
        logic [LUT_AW-3:0] sub;
        logic [LUT_AW-2:0] idx;
        logic [SAMPLE_W-1:0] mag;
        sub = a[LUT_AW-3:0];
        idx = a[LUT_AW-2] ? (LUT_AW - 1)'(2 ** (LUT_AW - 2)) - {1'b0, sub} : {1'b0, sub};
        mag = SAMPLE_W'(QTAB[idx]);
        lut_rd = a[LUT_AW-1] ? -mag : mag;
    endfunction

    logic [PHASE_W-1:0] acc_c, acc_m, acc_c_nxt, acc_m_nxt;
    logic               m_carry, unused_c_carry;
    logic [PHASE_W-1:0] pend_cfcw, pend_mfcw, act_cfcw, act_mfcw;
    logic [7:0]         pend_depth, act_depth;
    logic               pend, apply;

    assign {m_carry, acc_m_nxt}        = {1'b0, acc_m} + {1'b0, act_mfcw};
    assign {unused_c_carry, acc_c_nxt} = {1'b0, acc_c} + {1'b0, act_cfcw};

    // Apply at idle, with a stopped message, or on the message wrap so the envelope never jumps mid-period.
    assign apply   = pend & (~en | (act_mfcw == '0) | m_carry);
    assign cfg_ack = apply;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_c      <= '0;
            acc_m      <= '0;
            pend_cfcw  <= '0;
            pend_mfcw  <= '0;
            pend_depth <= '0;
            act_cfcw   <= '0;
            act_mfcw   <= '0;
            act_depth  <= '0;
            pend       <= 1'b0;
        end else begin
            if (en) begin
                acc_c <= acc_c_nxt;
                acc_m <= acc_m_nxt;
            end
            if (apply) begin
                act_cfcw  <= pend_cfcw;
                act_mfcw  <= pend_mfcw;
                act_depth <= pend_depth;
            end
            if (cfg_load) begin
                pend_cfcw  <= carrier_fcw;
                pend_mfcw  <= msg_fcw;
                pend_depth <= depth;
                pend       <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

    logic signed [SAMPLE_W-1:0] c1, m1, c2;
    logic [7:0]                 d1;
    logic                       v1, v2, v3, sc1;
    logic signed [ENV_W-1:0]    dm, env_nxt, env2;
    logic signed [PROD_W-1:0]   prod3;
    logic signed [PROD_W:0]     rsum, rsh;
    logic signed [OUT_W-1:0]    am_nxt;

`ifdef AM_DSB_SC_EN
    logic pend_sc, act_sc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_sc <= 1'b0;
            act_sc  <= 1'b0;
            sc1     <= 1'b0;
        end else begin
            if (apply)    act_sc  <= pend_sc;
            if (cfg_load) pend_sc <= sc_mode;
            sc1 <= act_sc;
        end
    end
`else
    logic unused_sc;
    assign unused_sc = sc_mode;
    assign sc1       = 1'b0;
`endif

    assign dm      = ENV_W'($signed({1'b0, d1})) * ENV_W'(m1);
    assign env_nxt = sc1 ? dm : ENV_OFS + dm;
    assign rsum    = (PROD_W + 1)'(prod3) + RND_HALF;
    assign rsh     = rsum >>> SH;

    always_comb begin
        am_nxt = rsh[OUT_W-1:0];
        if (rsh > OMAX)       am_nxt = OUT_W'(OMAX);
        else if (rsh < -OMAX) am_nxt = OUT_W'(-OMAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1       <= '0;
            m1       <= '0;
            d1       <= '0;
            v1       <= 1'b0;
            c2       <= '0;
            env2     <= '0;
            v2       <= 1'b0;
            prod3    <= '0;
            v3       <= 1'b0;
            am_out   <= '0;
            am_valid <= 1'b0;
        end else begin
            c1       <= lut_rd(acc_c[PHASE_W-1 -: LUT_AW]);
            m1       <= lut_rd(acc_m[PHASE_W-1 -: LUT_AW]);
            d1       <= act_depth;
            v1       <= en;
            c2       <= c1;
            env2     <= env_nxt;
            v2       <= v1;
            prod3    <= PROD_W'(env2) * PROD_W'(c2);
            v3       <= v2;
            am_valid <= v3;
            if (v3) am_out <= am_nxt;
        end
    end

endmodule

// File: tb/tb_am_mod_gen.sv
// Bench for am_mod_gen: spec-level reference model feeding a sample scoreboard, plus table vectors.
module tb_am_mod_gen;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               cfg_load = 1'b0;
    logic [31:0]        carrier_fcw = '0;
    logic [31:0]        msg_fcw = '0;
    logic [7:0]         depth = '0;
    logic               sc_mode = 1'b0;
    logic               cfg_ack;
    logic signed [13:0] am_out;
    logic               am_valid;

    always #5 clk = ~clk;

    am_mod_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
        .carrier_fcw(carrier_fcw), .msg_fcw(msg_fcw), .depth(depth), .sc_mode(sc_mode),
        .cfg_ack(cfg_ack), .am_out(am_out), .am_valid(am_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // reference model state
    logic [31:0] m_cacc, m_macc, a_cf, a_mf, p_cf, p_mf;
    logic [7:0]  a_d, p_d;
    logic        a_sc, p_sc, m_pend;
    logic [3:0]  vpipe;
    int          q[$];
    int          m_last;
    int          cyc = 0;
    int          ack_cyc;
    int          cap[8];
    int          cap_n;

    function automatic int lut_ref(input int k);
        real x;
        x = 127.0 * $sin(2.0 * 3.14159265358979 * k / 256.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic int model_out(input logic [31:0] ca, input logic [31:0] ma,
                                     input logic [7:0] d, input logic sc);
        logic [7:0] ci, mi;
        longint env, prod, r;
        ci = ca[31:24];
        mi = ma[31:24];
        env = longint'(int'(d) * lut_ref(int'(mi)));
        if (!sc) env = env + 32768;
        prod = env * lut_ref(int'(ci));
        r = (prod + 512) >>> 10;
        if (r > 8191) r = 8191;
        if (r < -8191) r = -8191;
        return int'(r);
    endfunction

    task automatic model_reset();
        m_cacc = '0; m_macc = '0;
        a_cf = '0; a_mf = '0; p_cf = '0; p_mf = '0;
        a_d = '0; p_d = '0; a_sc = 1'b0; p_sc = 1'b0; m_pend = 1'b0;
        vpipe = '0;
        q.delete();
        m_last = 0;
    endtask

    // One clock: check the combinational ack, advance the model, then check the registered outputs.
    task automatic tick();
        logic [32:0] s;
        logic carry, exp_ack;
        #1;
        s = {1'b0, m_macc} + {1'b0, a_mf};
        carry = en && s[32];
        exp_ack = m_pend && (!en || (a_mf == 0) || carry);
        chk("cfg_ack", cfg_ack, exp_ack);
        if (cfg_ack === 1'b1 && ack_cyc < 0) ack_cyc = cyc;
        if (en) begin
            q.push_back(model_out(m_cacc, m_macc, a_d, a_sc));
            m_cacc = m_cacc + a_cf;
            m_macc = m_macc + a_mf;
        end
        if (exp_ack) begin
            a_cf = p_cf; a_mf = p_mf; a_d = p_d; a_sc = p_sc;
        end
        if (cfg_load) begin
            p_cf = carrier_fcw; p_mf = msg_fcw; p_d = depth;
`ifdef AM_DSB_SC_EN
            p_sc = sc_mode;
`else
            p_sc = 1'b0;
`endif
            m_pend = 1'b1;
        end else if (exp_ack) begin
            m_pend = 1'b0;
        end
        vpipe = {vpipe[2:0], en};
        cyc++;
        @(posedge clk);
        #1;
        chk("am_valid", am_valid, vpipe[3]);
        if (am_valid === 1'b1) begin
            if (q.size() > 0) begin
                m_last = q.pop_front();
                chk("am_out", am_out, m_last);
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL am_out_extra: got sample %0d, expected none", am_out);
            end
            if (cap_n < 8) begin
                cap[cap_n] = am_out;
                cap_n++;
            end
        end else begin
            chk("am_out_hold", am_out, m_last);
        end
    endtask

    task automatic load_cfg(input logic [31:0] cf, input logic [31:0] mf, input logic [7:0] d, input logic sc);
        carrier_fcw = cf; msg_fcw = mf; depth = d; sc_mode = sc;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic run(input int n, input logic en_v);
        en = en_v;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        en = 1'b0;
        cfg_load = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_am_out", am_out, 0);
        chk("reset_am_valid", am_valid, 0);
        chk("reset_cfg_ack", cfg_ack, 0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] cf;
        logic [31:0] mf;
        logic [7:0]  d;
        int          exp[4];
    } vec_t;

    vec_t vecs[5];
    int   loadc;

    initial begin
        vecs[0] = '{cf: 32'h1000_0000, mf: 32'h0,         d: 8'd0,   exp: '{0, 1568, 2880, 3744}};
        vecs[1] = '{cf: 32'h4000_0000, mf: 32'h4000_0000, d: 8'd255, exp: '{0, 8080, 0, -48}};
        vecs[2] = '{cf: 32'h4000_0000, mf: 32'h4000_0000, d: 8'd0,   exp: '{0, 4064, 0, -4064}};
        vecs[3] = '{cf: 32'h2000_0000, mf: 32'h0,         d: 8'd77,  exp: '{0, 2880, 4064, 2880}};
        vecs[4] = '{cf: 32'h4000_0000, mf: 32'h4000_0000, d: 8'd128, exp: '{0, 6080, 0, -2048}};

        model_reset();
        ack_cyc = -1;
        cap_n = 0;
        @(posedge clk);
        #1;
        chk("por_am_out", am_out, 0);
        chk("por_am_valid", am_valid, 0);
        chk("por_cfg_ack", cfg_ack, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            do_reset();
            cap_n = 0;
            load_cfg(vecs[i].cf, vecs[i].mf, vecs[i].d, 1'b0);
            run(1, 1'b0);
            run(8, 1'b1);
            run(4, 1'b0);
            chk($sformatf("vec%0d_count", i), cap_n, 8);
            for (int j = 0; j < 4; j++)
                chk($sformatf("vec%0d_s%0d", i, j), cap[j], vecs[i].exp[j]);
        end

        // Deferred config: message wraps on en-cycle 15; load on cycle 18, ack due on cycle 31.
        do_reset();
        load_cfg(32'h0800_0000, 32'h1000_0000, 8'd64, 1'b0);
        run(1, 1'b0);
        run(18, 1'b1);
        ack_cyc = -1;
        loadc = cyc;
        load_cfg(32'h0C00_0000, 32'h0800_0000, 8'd200, 1'b0);
        run(20, 1'b1);
        chk("defer_ack_delay", ack_cyc - loadc, 13);

        // Idle config: ack next cycle, phase preserved across the pause.
        run(6, 1'b0);
        load_cfg(32'h0340_0000, 32'h0123_4567, 8'd180, 1'b0);
        #1 chk("idle_ack", cfg_ack, 1);
        run(1, 1'b0);
        load_cfg(32'h0200_0000, 32'h0100_0000, 8'd10, 1'b0);
        load_cfg(32'h0280_0000, 32'h0180_0000, 8'd240, 1'b0);
        run(2, 1'b0);
        run(12, 1'b1);
        run(5, 1'b0);

        // Reset mid-stream, then restart from phase zero.
        load_cfg(32'h4000_0000, 32'h4000_0000, 8'd255, 1'b0);
        run(1, 1'b0);
        run(6, 1'b1);
        chk("pre_reset_valid", am_valid, 1);
        do_reset();
        load_cfg(32'h4000_0000, 32'h4000_0000, 8'd255, 1'b0);
        run(1, 1'b0);
        cap_n = 0;
        run(6, 1'b1);
        run(4, 1'b0);
        chk("post_reset_s0", cap[0], 0);
        chk("post_reset_s1", cap[1], 8080);

`ifdef AM_DSB_SC_EN
        do_reset();
        load_cfg(32'h4000_0000, 32'h4000_0000, 8'd255, 1'b1);
        run(1, 1'b0);
        cap_n = 0;
        run(8, 1'b1);
        run(4, 1'b0);
        chk("sc_s0", cap[0], 0);
        chk("sc_s1", cap[1], 4016);
        chk("sc_s3", cap[3], 4016);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
